// File: rtl/volume_request_engine.sv
// Volume request engine: takes one block read/write command at a time,
// checks it against the volume status, drives a 4-phase rd/wr + ack
// handshake towards the volume firmware and reports a completion status.
module volume_request_engine #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_lba,
   input  logic [5:0]  cmd_blk_cnt,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [2:0]  resp_status,
   input  logic        vol_ready,
   input  logic        vol_mounted,
   input  logic        vol_readonly,
   input  logic        vol_ack,
   input  logic [31:0] vol_size,
   output logic        vol_active,
   output logic        vol_rd,
   output logic        vol_wr,
   output logic [31:0] vol_lba,
   output logic [5:0]  vol_blk_cnt
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CHECK   = 3'd1,
      REQ     = 3'd2,
      RELEASE = 3'd3,
      RESP    = 3'd4
   } state_t;

   localparam logic [2:0] ST_OK       = 3'd0;
   localparam logic [2:0] ST_NOTREADY = 3'd1;
   localparam logic [2:0] ST_WPROT    = 3'd2;
   localparam logic [2:0] ST_RANGE    = 3'd3;
   localparam logic [2:0] ST_TIMEOUT  = 3'd4;

   localparam logic [32:0] TIMEOUT_LIMIT = 33'(TIMEOUT_CYCLES);

   state_t      state;
   state_t      state_next;
   logic [2:0]  status_q;
   logic [2:0]  status_next;
   logic [2:0]  check_status;
   logic        write_q;
   logic [31:0] lba_q;
   logic [5:0]  cnt_q;
   logic [31:0] timeout_cnt;
   logic        accept;
   logic        range_err;
   logic        timeout_hit;

   assign accept = cmd_valid && cmd_ready;

   // 33-bit sum so an lba near 2^32 cannot wrap around and look in range
   assign range_err = (cnt_q == 6'd0) ||
                      (({1'b0, lba_q} + {27'd0, cnt_q}) > {1'b0, vol_size});

   // The current REQ cycle is the TIMEOUT_CYCLES-th one; zero disables it
   assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                        (({1'b0, timeout_cnt} + 33'd1) >= TIMEOUT_LIMIT);

   assign resp_status = status_q;
   assign vol_lba     = lba_q;
   assign vol_blk_cnt = cnt_q;

   // Admission check on the registered command, in priority order
   always_comb begin
      check_status = ST_OK;
      if (!vol_ready || !vol_mounted) begin
         check_status = ST_NOTREADY;
      end else if (write_q && vol_readonly) begin
         check_status = ST_WPROT;
      end else if (range_err) begin
         check_status = ST_RANGE;
      end
   end

   // State and completion status registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         status_q <= ST_OK;
      end else begin
         state    <= state_next;
         status_q <= status_next;
      end
   end

   // Capture the command on accept; these values stay on vol_lba/vol_blk_cnt
   always_ff @(posedge clk) begin
      if (reset) begin
         write_q <= 1'b0;
         lba_q   <= 32'd0;
         cnt_q   <= 6'd0;
      end else if (accept) begin
         write_q <= cmd_write;
         lba_q   <= cmd_lba;
         cnt_q   <= cmd_blk_cnt;
      end
   end

   // Counts REQ cycles; sits at zero everywhere else so each REQ starts fresh
   always_ff @(posedge clk) begin
      if (reset || (state != REQ)) begin
         timeout_cnt <= 32'd0;
      end else begin
         timeout_cnt <= timeout_cnt + 32'd1;
      end
   end

   // Next-state and output decode; ack beats any error raised in the same REQ cycle
   always_comb begin
      state_next  = state;
      status_next = status_q;
      cmd_ready   = 1'b0;
      resp_valid  = 1'b0;
      vol_active  = 1'b0;
      vol_rd      = 1'b0;
      vol_wr      = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = !vol_ack;
            if (cmd_valid && !vol_ack) begin
               state_next = CHECK;
            end
         end
         CHECK: begin
            vol_active = 1'b1;
            if (check_status != ST_OK) begin
               status_next = check_status;
               state_next  = RESP;
            end else begin
               state_next = REQ;
            end
         end
         REQ: begin
            vol_active = 1'b1;
            vol_rd     = !write_q;
            vol_wr     = write_q;
            if (vol_ack) begin
               status_next = ST_OK;
               state_next  = RELEASE;
            end else if (!vol_ready || !vol_mounted) begin
               status_next = ST_NOTREADY;
               state_next  = RELEASE;
            end else if (timeout_hit) begin
               status_next = ST_TIMEOUT;
               state_next  = RELEASE;
            end
         end
         RELEASE: begin
            vol_active = 1'b1;
            if (!vol_ack) begin
               state_next = RESP;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_volume_request_engine.sv
// Bench for volume_request_engine: directed commands against a transaction
// level reference, compared every cycle, plus literal timing/status checks.
module tb_volume_request_engine;

   localparam int TB_TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_lba;
   logic [5:0]  cmd_blk_cnt;
   logic        resp_valid;
   logic        resp_ready;
   logic [2:0]  resp_status;
   logic        vol_ready;
   logic        vol_mounted;
   logic        vol_readonly;
   logic        vol_ack;
   logic [31:0] vol_size;
   logic        vol_active;
   logic        vol_rd;
   logic        vol_wr;
   logic [31:0] vol_lba;
   logic [5:0]  vol_blk_cnt;

   int vectors = 0;
   int miscompares = 0;

   volume_request_engine #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_lba(cmd_lba), .cmd_blk_cnt(cmd_blk_cnt),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_status(resp_status),
      .vol_ready(vol_ready), .vol_mounted(vol_mounted), .vol_readonly(vol_readonly),
      .vol_ack(vol_ack), .vol_size(vol_size),
      .vol_active(vol_active), .vol_rd(vol_rd), .vol_wr(vol_wr),
      .vol_lba(vol_lba), .vol_blk_cnt(vol_blk_cnt)
   );

   always #5 clk = ~clk;

   // Reference: where the current command is in its life and what it must report
   bit          model_live = 1'b0;
   bit          m_check, m_req, m_release, m_resp;
   logic [2:0]  m_status;
   logic        m_write;
   logic [31:0] m_lba;
   logic [5:0]  m_cnt;
   int          m_req_cycles;

   function automatic logic [2:0] admitStatus(input logic w, input logic [31:0] l,
                                              input logic [5:0] c);
      longint unsigned last;
      last = longint'({32'd0, l}) + longint'({58'd0, c});
      if (!vol_ready || !vol_mounted) return 3'd1;
      if (w && vol_readonly) return 3'd2;
      if (c == 6'd0 || last > longint'({32'd0, vol_size})) return 3'd3;
      return 3'd0;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic failBound(input string name);
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s wait bound expired at %0t", name, $time);
   endtask

   // Advance the reference one clock using the inputs seen at this edge
   always @(posedge clk) begin
      model_live <= 1'b1;
      if (reset) begin
         m_check <= 0; m_req <= 0; m_release <= 0; m_resp <= 0;
         m_status <= 3'd0; m_write <= 1'b0; m_lba <= 32'd0; m_cnt <= 6'd0;
         m_req_cycles <= 0;
      end else if (m_resp) begin
         if (resp_ready) m_resp <= 0;
      end else if (m_release) begin
         if (!vol_ack) begin m_release <= 0; m_resp <= 1; end
      end else if (m_req) begin
         m_req_cycles <= m_req_cycles + 1;
         if (vol_ack) begin
            m_status <= 3'd0; m_req <= 0; m_release <= 1;
         end else if (!vol_ready || !vol_mounted) begin
            m_status <= 3'd1; m_req <= 0; m_release <= 1;
         end else if (m_req_cycles + 1 == TB_TIMEOUT) begin
            m_status <= 3'd4; m_req <= 0; m_release <= 1;
         end
      end else if (m_check) begin
         m_check <= 0;
         if (admitStatus(m_write, m_lba, m_cnt) != 3'd0) begin
            m_status <= admitStatus(m_write, m_lba, m_cnt);
            m_resp <= 1;
         end else begin
            m_req <= 1; m_req_cycles <= 0;
         end
      end else if (cmd_valid && !vol_ack) begin
         m_write <= cmd_write; m_lba <= cmd_lba; m_cnt <= cmd_blk_cnt;
         m_check <= 1;
      end
   end

   // Compare every DUT output against the reference mid-cycle
   always @(negedge clk) begin
      if (model_live) begin
         checkOutput("cmd_ready", cmd_ready, !(m_check || m_req || m_release || m_resp) && !vol_ack);
         checkOutput("vol_active", vol_active, m_check || m_req || m_release);
         checkOutput("vol_rd", vol_rd, m_req && !m_write);
         checkOutput("vol_wr", vol_wr, m_req && m_write);
         checkOutput("vol_lba", vol_lba, m_lba);
         checkOutput("vol_blk_cnt", vol_blk_cnt, m_cnt);
         checkOutput("resp_valid", resp_valid, m_resp);
         checkOutput("resp_status", resp_status, m_status);
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Offer one command and hold it exactly for its accept cycle; returns in CHECK
   task automatic applyStimulus(input logic w, input logic [31:0] l, input logic [5:0] c);
      int n = 0;
      while (!cmd_ready && n < 50) begin
         waitCycles(1);
         n++;
      end
      if (!cmd_ready) failBound("cmd_ready_wait");
      cmd_write = w; cmd_lba = l; cmd_blk_cnt = c; cmd_valid = 1'b1;
      waitCycles(1);
      cmd_valid = 1'b0;
   endtask

   task automatic awaitResp(input string name, input logic [2:0] exp);
      int n = 0;
      while (!resp_valid && n < 50) begin
         waitCycles(1);
         n++;
      end
      if (!resp_valid) begin
         failBound(name);
      end else begin
         checkOutput(name, resp_status, exp);
         resp_ready = 1'b1;
         waitCycles(1);
         resp_ready = 1'b0;
      end
   endtask

   // Full command with a firmware that acks after ack_delay strobe cycles (<0: never)
   task automatic runCmd(input string name, input logic w, input logic [31:0] l,
                         input logic [5:0] c, input int ack_delay, input logic [2:0] exp);
      int strobe = 0;
      applyStimulus(w, l, c);
      for (int i = 0; i < 60 && !resp_valid; i++) begin
         if (vol_ack && !vol_rd && !vol_wr) begin
            vol_ack = 1'b0;
         end else if (vol_rd || vol_wr) begin
            strobe++;
            if (ack_delay >= 0 && strobe >= ack_delay) vol_ack = 1'b1;
         end
         waitCycles(1);
      end
      awaitResp(name, exp);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL global_watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n;
      reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_lba = 32'd0; cmd_blk_cnt = 6'd0;
      resp_ready = 1'b0; vol_ready = 1'b1; vol_mounted = 1'b1; vol_readonly = 1'b0;
      vol_ack = 1'b0; vol_size = 32'd100;
      waitCycles(3);
      reset = 1'b0;
      waitCycles(1);
      checkOutput("reset_cmd_ready", cmd_ready, 1);
      checkOutput("reset_vol_lba", vol_lba, 0);

      // Read OK: strobe at accept+2, ack during the fifth strobe cycle
      $display("[TB] read ok");
      applyStimulus(1'b0, 32'd10, 6'd4);
      checkOutput("rd_accept_plus1", vol_rd, 0);
      waitCycles(1);
      checkOutput("rd_accept_plus2", vol_rd, 1);
      checkOutput("rd_lba", vol_lba, 10);
      checkOutput("rd_cnt", vol_blk_cnt, 4);
      waitCycles(4);
      vol_ack = 1'b1;
      waitCycles(1);
      checkOutput("rd_drop_after_ack", vol_rd, 0);
      vol_ack = 1'b0;
      waitCycles(1);
      checkOutput("rd_active_in_resp", vol_active, 0);
      awaitResp("read_ok_status", 3'd0);

      // Write protect: response already at accept+2, no write strobe
      $display("[TB] write protect");
      vol_readonly = 1'b1;
      applyStimulus(1'b1, 32'd0, 6'd1);
      waitCycles(1);
      checkOutput("wprot_resp_at_plus2", resp_valid, 1);
      checkOutput("wprot_no_wr", vol_wr, 0);
      awaitResp("wprot_status", 3'd2);
      vol_readonly = 1'b0;

      // Range edges and a successful write
      $display("[TB] range");
      runCmd("range_97_4", 1'b0, 32'd97, 6'd4, 2, 3'd3);
      runCmd("range_96_4", 1'b0, 32'd96, 6'd4, 2, 3'd0);
      runCmd("range_wrap", 1'b0, 32'hFFFF_FFFF, 6'd1, 2, 3'd3);
      runCmd("range_cnt0", 1'b0, 32'd5, 6'd0, 2, 3'd3);
      runCmd("write_ok", 1'b1, 32'd20, 6'd3, 1, 3'd0);

      // Not ready at admission and while strobing
      $display("[TB] not ready");
      vol_ready = 1'b0;
      runCmd("notready_check", 1'b0, 32'd1, 6'd1, 2, 3'd1);
      vol_ready = 1'b1;
      vol_mounted = 1'b0;
      runCmd("unmounted_check", 1'b1, 32'd1, 6'd1, 2, 3'd1);
      vol_mounted = 1'b1;
      applyStimulus(1'b0, 32'd3, 6'd2);
      waitCycles(1);
      vol_mounted = 1'b0;
      waitCycles(1);
      checkOutput("notready_req_rd_drop", vol_rd, 0);
      vol_mounted = 1'b1;
      awaitResp("notready_req_status", 3'd1);

      // Timeout: exactly TB_TIMEOUT strobe cycles, then a late ack in release
      $display("[TB] timeout");
      applyStimulus(1'b0, 32'd0, 6'd8);
      waitCycles(1);
      n = 0;
      while (vol_rd && n < 50) begin
         n++;
         waitCycles(1);
      end
      checkOutput("timeout_rd_cycles", n, 8);
      vol_ack = 1'b1;
      waitCycles(1);
      checkOutput("timeout_late_ack_held", resp_valid, 0);
      vol_ack = 1'b0;
      awaitResp("timeout_status", 3'd4);

      // Ack in the very cycle the timeout would fire
      applyStimulus(1'b0, 32'd0, 6'd8);
      waitCycles(8);
      vol_ack = 1'b1;
      waitCycles(1);
      checkOutput("ack_vs_timeout_rd", vol_rd, 0);
      vol_ack = 1'b0;
      awaitResp("ack_vs_timeout_status", 3'd0);

      // Reset while strobing, firmware still holding ack
      $display("[TB] reset mid request");
      applyStimulus(1'b0, 32'd40, 6'd5);
      waitCycles(1);
      vol_ack = 1'b1;
      reset = 1'b1;
      waitCycles(1);
      reset = 1'b0;
      checkOutput("rst_rd", vol_rd, 0);
      checkOutput("rst_active", vol_active, 0);
      checkOutput("rst_resp_valid", resp_valid, 0);
      checkOutput("rst_cmd_ready_ack", cmd_ready, 0);
      waitCycles(3);
      checkOutput("rst_cmd_ready_held", cmd_ready, 0);
      vol_ack = 1'b0;
      #1;
      checkOutput("rst_cmd_ready_rise", cmd_ready, 1);
      waitCycles(1);

      // Back-pressure: response held, no new command taken meanwhile
      $display("[TB] back pressure");
      applyStimulus(1'b0, 32'd1, 6'd0);
      waitCycles(1);
      cmd_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         checkOutput("bp_resp_valid", resp_valid, 1);
         checkOutput("bp_status", resp_status, 3);
         checkOutput("bp_cmd_ready", cmd_ready, 0);
         waitCycles(1);
      end
      cmd_valid = 1'b0;
      awaitResp("bp_final_status", 3'd3);
      waitCycles(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/volume_request_engine.md
VOLUME_REQUEST_ENGINE -- requirements
Module: volume_request_engine

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000, max clk cycles waiting for ack rise; 0 disables timeout.
REQ-002 SHALL have ports: clk  in  1  system clock, sole clock domain.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 cmd_valid  in  1  command offered; cmd_ready  out  1  engine can accept.
REQ-005 cmd_write  in  1  1=block write, 0=block read.
REQ-006 cmd_lba  in  32  first block; cmd_blk_cnt  in  6  block count.
REQ-007 resp_valid  out  1  command finished; resp_ready  in  1  consumer takes response.
REQ-008 resp_status  out  3  0=OK, 1=NOTREADY, 2=WPROT, 3=RANGE, 4=TIMEOUT.
REQ-009 vol_ready, vol_mounted, vol_readonly, vol_ack  in  1 each  responder (firmware) status/ack.
REQ-010 vol_size  in  32  volume size in blocks.
REQ-011 vol_active  out  1; vol_rd, vol_wr  out  1; vol_lba  out  32; vol_blk_cnt  out  6  requester side of drive volume handshake.

Function
REQ-012 States: IDLE, CHECK, REQ, RELEASE, RESP.
REQ-013 cmd_ready SHALL be 1 only in IDLE with vol_ack=0; accept when cmd_valid&&cmd_ready, registering write/lba/blk_cnt; next state CHECK.
REQ-014 vol_active SHALL be 1 from cycle after accept until the cycle RESP is entered, else 0.
REQ-015 CHECK (one cycle) priority: !vol_ready||!vol_mounted -> NOTREADY; write&&vol_readonly -> WPROT; blk_cnt==0 or 33-bit (lba+blk_cnt) > vol_size -> RANGE; else OK.
REQ-016 CHECK error -> RESP with status, no rd/wr pulse; CHECK OK -> REQ.
REQ-017 In REQ: vol_rd=!write, vol_wr=write, vol_lba/vol_blk_cnt = registered values, held stable; vol_rd and vol_wr never both 1.
REQ-018 First vol_rd/vol_wr assertion SHALL occur 2 cycles after accept cycle.
REQ-019 REQ exits on first cycle vol_ack=1 -> RELEASE, status OK; rd/wr drop the following cycle.
REQ-020 In REQ, vol_ready or vol_mounted low (ack=0) -> status NOTREADY, go RELEASE.
REQ-021 Timeout counter (32-bit) cleared on REQ entry, increments each REQ cycle; reaching TIMEOUT_CYCLES with ack=0 -> status TIMEOUT, RELEASE; TIMEOUT_CYCLES=0 never times out.
REQ-022 Simultaneous ack=1 and timeout/NOTREADY in same cycle: ack wins, status OK.
REQ-023 RELEASE: rd=wr=0; wait until vol_ack=0 (4-phase handshake, no timeout), then RESP.
REQ-024 RESP: resp_valid=1, resp_status stable; leaves to IDLE on resp_valid&&resp_ready; IDLE reachable that same edge, so next accept no earlier than following cycle.
REQ-025 vol_lba/vol_blk_cnt SHALL hold last command values outside REQ; status inputs sampled only in CHECK/REQ.

Reset
REQ-026 reset=1 at any clk edge, including mid-REQ, SHALL force IDLE next cycle: cmd_ready=!vol_ack, resp_valid=0, resp_status=0, vol_active=0, vol_rd=0, vol_wr=0, vol_lba=0, vol_blk_cnt=0, timeout counter=0.
REQ-027 No command pending across reset; responder sees rd/wr fall, any late ack is absorbed by cmd_ready gating.

Verification
REQ-028 Read OK: size=100, ready=mounted=1, cmd lba=10 cnt=4 rd -> vol_rd=1 at accept+2, lba=10 cnt=4; ack after 5 cycles -> rd=0 next cycle; ack low -> resp_status=0.
REQ-029 Write protect: readonly=1, cmd_write lba=0 cnt=1 -> no vol_wr pulse, resp_status=2 at accept+2.
REQ-030 Range: size=100, lba=97 cnt=4 -> status 3; lba=96 cnt=4 -> OK; lba=FFFFFFFF cnt=1 -> status 3 (no 32-bit wrap); cnt=0 -> 3.
REQ-031 Timeout: TIMEOUT_CYCLES=8, never ack -> rd high 8 cycles then drops, status 4; late ack pulse in RELEASE still waited out; ack+timeout same cycle -> status 0.
REQ-032 Reset mid-REQ: reset with vol_rd=1 -> next cycle rd=0, active=0, resp_valid=0; cmd_ready stays 0 while ack held 1, rises when ack=0.
REQ-033 Back-pressure: resp_ready=0 for 10 cycles -> resp_valid/status stable, cmd_ready=0 throughout.
